// File: rtl/apb_master_bridge_pkg.sv
// Shared APB master definitions: FSM state encoding, bus widths and default timeout.
// Also used by apb_sram and its bench for the common address/data widths.
package apb_master_pkg;

    localparam int APB_ADDR_W  = 12;
    localparam int APB_DATA_W  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB master: turns one valid/ready word request into one SETUP/ACCESS transfer
// and returns data/status through a single-entry response register, with wait-state timeout.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               psel_q;
    logic               penable_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic               pwrite_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;

    // Only one transaction in flight: accept only when idle and the response slot is empty.
    assign req_ready = (state_q == ST_IDLE) && !rsp_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_addr[1:0] != 2'b00) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q  <= ST_SETUP;
                            psel_q   <= 1'b1;
                            paddr_q  <= req_addr;
                            pwrite_q <= req_write;
                            pwdata_q <= req_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= (pwrite_q || pslverr) ? '0 : prdata;
                    end else if (cnt_q == CNT_LAST) begin
                        // Slave never answered within the budget: abort and report an error.
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Synthesizable APB master that sits directly upstream of apb_sram and replaces the behavioural bus-driving model in on-chip use.
- Accepts word read/write requests on a valid/ready command interface.
- Converts each request into one APB SETUP/ACCESS transfer and returns read data and status on a valid/ready response interface.
- Includes a wait-state timeout so a stuck slave cannot hang the requester.

Parameters:
- ADDR_W, 12, APB/request address width in bytes; word-aligned, bits [1:0] must be 0.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort (range 1..255).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, timeout, or misaligned address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- pslverr  in  1  slave error; tie 0 when the slave has none.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values: psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State=IDLE. Timeout counter=0.
- All outputs are registered except req_ready.
- req_ready = (state==IDLE) && !rsp_valid. There is one outstanding transaction at most and a one-entry response slot.
- Handshake: a transfer occurs on a posedge with valid&&ready. A valid signal, once raised, holds its payload until accepted (requester rule). The bridge holds rsp_* stable while rsp_valid && !rsp_ready.
- State IDLE, request accepted with req_addr[1:0]!=0 → state ERR. No APB activity.
- State ERR: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0 → IDLE.
- State IDLE, aligned request accepted → state SETUP. psel=1, penable=0. paddr, pwrite and pwdata are captured from the request.
- State SETUP → state ACCESS. penable=1. Counter cleared.
- State ACCESS:
  - pready=1 on a posedge: psel=0, penable=0, rsp_valid=1, rsp_err=pslverr, rsp_rdata=(pwrite||pslverr)?0:prdata → IDLE.
  - pready=0: counter increments.
  - Counter reaches TIMEOUT-1 with pready still 0: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0 → IDLE.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. They hold their last value in IDLE; they are not cleared.
- Latency with a zero-wait slave: request accepted at edge T0. psel=1 after T0, penable=1 after T1, completion at edge T2, rsp_valid=1 after T2. That is 3 cycles from accept to response.
- Each wait state adds 1 cycle.
- Back-to-back throughput is 1 transfer per 4 cycles when rsp_ready is tied 1. req_ready rises the cycle after rsp_valid&&rsp_ready.
- rsp_valid clears on a posedge with rsp_ready=1. rsp_rdata and rsp_err keep their values; they are don't-care while rsp_valid=0.
- Reset mid-ACCESS: all outputs return to reset values immediately (asynchronous). Any pending response is dropped.
- Counter width: 8 bits.

Decomposition:
- Shared package apb_master_pkg holds:
  - state encoding IDLE/SETUP/ACCESS/ERR (2-bit enum);
  - APB_ADDR_W=12 and APB_DATA_W=32, also used by apb_sram and its bench;
  - default TIMEOUT constant.
- No sub-module. The FSM, counter and response register are one flat module.

Test Plan:
- Write 0xDEADBEEF to 0x000, then read 0x000 with zero-wait apb_sram → write rsp_err=0, rsp_rdata=0. Read rsp_rdata=0xDEADBEEF. The sp_sram mem_r[0] backdoor equals 0xDEADBEEF. psel high exactly 2 cycles per transfer.
- Boundary: write 0x12345678 to 0xFFC, read it back → mem_r[1023]=0x12345678, rsp_rdata=0x12345678, no aliasing into mem_r[0].
- Wait states: stub slave holds pready=0 for 3 ACCESS cycles on a read returning 0xA5A5A5A5 → penable high 4 cycles, paddr stable throughout, rsp_valid 6 cycles after accept, rsp_rdata=0xA5A5A5A5.
- Timeout and slave error:
  - pready held 0 → psel drops after exactly TIMEOUT=16 ACCESS cycles; rsp_err=1, rsp_rdata=0.
  - pready=1 with pslverr=1 → rsp_err=1.
- Misaligned address and backpressure:
  - req_addr=0x002 → no psel pulse, rsp_err=1 two cycles after accept.
  - rsp_ready held 0 for 5 cycles → rsp_* stable and req_ready=0 until the response is accepted.
- Reset mid-transfer: assert rstn=0 during ACCESS → psel, penable and rsp_valid go 0 immediately. After release the first request completes normally (write 0x0BADF00D to 0x010, read back matches).
